// File: rtl/fpu_op_scheduler.sv
// fpu_op_scheduler
//
// Arbitrates two requesters onto one combinational floating-point ALU.
// Only one operation is in flight at a time. The operands are held steady on
// the ALU inputs for a latency that depends on the opcode. The ALU result and
// flags are then captured and offered on the response port until the
// consumer accepts them.
//
// Ports:
//   clk, rst_n                        clock (rising edge), async active-low reset
//   reqN_valid/ready/a/b/oper         requester N operation handshake (N = 0, 1)
//   alu_in1, alu_in2, alu_oper        operands and opcode driven to the ALU
//   alu_result, alu_overflow,
//   alu_underflow, alu_exception      ALU result and flags
//   rsp_valid/ready/id/result/flags   response handshake; flags = {ovf, unf, exc}
//   busy                              high whenever an operation is in flight
//   err_count                         saturating count of flagged responses
module fpu_op_scheduler #(
    parameter int unsigned LAT_ADDSUB = 1,
    parameter int unsigned LAT_MUL    = 2,
    parameter int unsigned LAT_DIV    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [1:0]  req0_oper,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [1:0]  req1_oper,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [1:0]  alu_oper,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    input  logic        alu_underflow,
    input  logic        alu_exception,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [2:0]  rsp_flags,
    output logic        busy,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        grant;
    logic        accept;
    logic        capture;
    logic        rsp_done;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [1:0]  sel_oper;
    logic [3:0]  sel_lat;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  op_oper;
    logic        op_id;
    logic [3:0]  count;
    logic        last_grant;

    // Arbitration: a lone requester always wins; on a tie the requester that
    // was not served last wins. Ready is only offered while IDLE, so a request
    // that arrives during EXEC/RESP simply waits with valid held high.
    always_comb begin
        grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        req0_ready = (state == IDLE) && req0_valid && !grant;
        req1_ready = (state == IDLE) && req1_valid && grant;
        accept     = req0_ready || req1_ready;
        sel_a      = grant ? req1_a    : req0_a;
        sel_b      = grant ? req1_b    : req0_b;
        sel_oper   = grant ? req1_oper : req0_oper;
        case (sel_oper)
            2'b10:   sel_lat = 4'(LAT_MUL);
            2'b11:   sel_lat = 4'(LAT_DIV);
            default: sel_lat = 4'(LAT_ADDSUB);
        endcase
    end

    // Capture on count <= 1 rather than == 1 so that an out-of-range zero
    // latency still completes instead of wrapping the counter and stalling.
    always_comb begin
        capture  = (state == EXEC) && (count <= 4'd1);
        rsp_done = (state == RESP) && rsp_ready;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)   state_next = EXEC;
            EXEC:    if (capture)  state_next = RESP;
            RESP:    if (rsp_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand, counter and response registers. last_grant resets to 1 so
    // requester 0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            op_oper    <= 2'd0;
            op_id      <= 1'b0;
            count      <= 4'd0;
            last_grant <= 1'b1;
            rsp_result <= 32'd0;
            rsp_flags  <= 3'd0;
            err_count  <= 16'd0;
        end else begin
            if (accept) begin
                op_a       <= sel_a;
                op_b       <= sel_b;
                op_oper    <= sel_oper;
                op_id      <= grant;
                count      <= sel_lat;
                last_grant <= grant;
            end else if (state == EXEC) begin
                count <= count - 4'd1;
            end
            if (capture) begin
                rsp_result <= alu_result;
                rsp_flags  <= {alu_overflow, alu_underflow, alu_exception};
            end
            if (rsp_done && (|rsp_flags) && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

    assign alu_in1   = op_a;
    assign alu_in2   = op_b;
    assign alu_oper  = op_oper;
    assign rsp_id    = op_id;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// tb_fpu_op_scheduler
//
// Self-checking bench for fpu_op_scheduler. A stub ALU answers the scheduler
// combinationally. Directed operand pairs give true IEEE results; other pairs
// give a scrambled value. An accept monitor pushes the expected response of
// every accepted operation onto a scoreboard queue. Each test task pops the
// queue when a response appears and compares it inline.
module tb_fpu_op_scheduler;

    localparam int LAT_ADDSUB = 1;
    localparam int LAT_MUL    = 2;
    localparam int LAT_DIV    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]  req0_oper = '0, req1_oper = '0;
    logic [31:0] alu_in1, alu_in2, alu_result;
    logic [1:0]  alu_oper;
    logic        alu_overflow, alu_underflow, alu_exception;
    logic        rsp_valid, rsp_id, busy;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_flags;
    logic [15:0] err_count;

    typedef struct {
        logic        id;
        logic [31:0] result;
        logic [2:0]  flags;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;
    logic [15:0] exp_err = 16'd0;

    always #5 clk = ~clk;

    fpu_op_scheduler #(
        .LAT_ADDSUB(LAT_ADDSUB),
        .LAT_MUL(LAT_MUL),
        .LAT_DIV(LAT_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_oper(req0_oper),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_oper(req1_oper),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_oper(alu_oper),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .alu_underflow(alu_underflow), .alu_exception(alu_exception),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .busy(busy), .err_count(err_count)
    );

    // Stub ALU: {overflow, underflow, exception, result}. An infinity operand
    // raises the exception flag and returns a quiet NaN.
    function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        logic        exc;
        logic [31:0] r;
        exc = (a == 32'h7F800000) || (b == 32'h7F800000);
        if (exc)
            r = 32'h7FC00000;
        else if (a == 32'h3F800000 && b == 32'h40000000 && op == 2'b00)
            r = 32'h40400000;
        else if (a == 32'h40000000 && b == 32'h40400000 && op == 2'b10)
            r = 32'h40C00000;
        else if (a == 32'h3F800000 && b == 32'h3F800000 && op == 2'b00)
            r = 32'h40000000;
        else
            r = a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
        return {2'b00, exc, r};
    endfunction

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'b10:   return LAT_MUL;
            2'b11:   return LAT_DIV;
            default: return LAT_ADDSUB;
        endcase
    endfunction

    function automatic exp_t make_exp(input logic id, input logic [31:0] a, input logic [31:0] b,
                                      input logic [1:0] op, input int c);
        exp_t        e;
        logic [34:0] m;
        m = alu_model(a, b, op);
        e.id      = id;
        e.result  = m[31:0];
        e.flags   = m[34:32];
        e.lat     = lat_of(op);
        e.acc_cyc = c;
        return e;
    endfunction

    assign {alu_overflow, alu_underflow, alu_exception, alu_result} =
        alu_model(alu_in1, alu_in2, alu_oper);

    always @(posedge clk) cyc <= cyc + 1;

    // Accept monitor: fills the scoreboard at the handshake edge.
    always @(posedge clk) begin
        if (req0_valid && req0_ready) exp_q.push_back(make_exp(1'b0, req0_a, req0_b, req0_oper, cyc));
        if (req1_valid && req1_ready) exp_q.push_back(make_exp(1'b1, req1_a, req1_b, req1_oper, cyc));
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_err = 16'd0;
    endtask

    task automatic set_req(input int id, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [1:0] op);
        if (id == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_oper = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_oper = op;
        end
    endtask

    task automatic wait_ready(input int id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if ((id == 0) ? req0_ready : req1_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Issues one operation from a single requester and waits for its
    // response; ok is low if either handshake never came.
    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, output exp_t e, output int n, output bit ok);
        bit rdy;
        @(negedge clk);
        set_req(id, 1'b1, a, b, op);
        #1;
        wait_ready(id, rdy);
        @(negedge clk);
        set_req(id, 1'b0, a, b, op);
        wait_rsp(n);
        ok = rdy && rsp_valid && (exp_q.size() > 0);
        if (ok) e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if ({busy, rsp_valid, req0_ready, req1_ready} !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: busy/rsp_valid/rdy0/rdy1 = %b, want 0000",
                     {busy, rsp_valid, req0_ready, req1_ready});
        end
        checks++;
        if ({alu_in1, alu_in2, alu_oper, rsp_result, rsp_flags, err_count} !== 103'd0) begin
            fails++;
            $display("[TB] FAIL reset_regs: in1=%h in2=%h op=%b res=%h flg=%b err=%h, want all 0",
                     alu_in1, alu_in2, alu_oper, rsp_result, rsp_flags, err_count);
        end
    endtask

    task automatic test_single_add();
        bit   ok;
        int   n;
        exp_t e;
        @(negedge clk);
        set_req(0, 1'b1, 32'h3F800000, 32'h40000000, 2'b00);
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL add_ready: req0_ready=%b, want 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++;
        if ({busy, rsp_valid, alu_in1, alu_in2, alu_oper} !== {2'b10, 32'h3F800000, 32'h40000000, 2'b00}) begin
            fails++;
            $display("[TB] FAIL add_exec: busy=%b rsp_valid=%b in1=%h in2=%h op=%b, want 1 0 3f800000 40000000 00",
                     busy, rsp_valid, alu_in1, alu_in2, alu_oper);
        end
        wait_rsp(n);
        checks++;
        if (n !== LAT_ADDSUB) begin
            fails++;
            $display("[TB] FAIL add_latency: %0d cycles, want %0d", n, LAT_ADDSUB);
        end
        ok = rsp_valid && (exp_q.size() > 0);
        if (ok) e = exp_q.pop_front();
        checks++;
        if (!ok || {rsp_result, rsp_id, rsp_flags} !== {32'h40400000, 1'b0, 3'b000}
                || rsp_result !== e.result) begin
            fails++;
            $display("[TB] FAIL add_rsp: ok=%b res=%h id=%b flg=%b, want 40400000 0 000",
                     ok, rsp_result, rsp_id, rsp_flags);
        end
        @(negedge clk);
        checks++;
        if ({busy, rsp_valid} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL add_done: busy=%b rsp_valid=%b, want 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        bit   ok;
        int   n;
        exp_t e;
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(1, 1'b1, 32'h40000000, 32'h40400000, 2'b10);
        #1;
        wait_ready(1, ok);
        @(negedge clk);
        req1_valid = 1'b0;
        set_req(0, 1'b1, 32'h3F800000, 32'h3F800000, 2'b00);
        wait_rsp(n);
        checks++;
        if (n !== LAT_MUL || !ok) begin
            fails++;
            $display("[TB] FAIL mul_latency: %0d cycles (accepted=%b), want %0d", n, ok, LAT_MUL);
        end
        ok = (exp_q.size() > 0);
        if (ok) e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, busy, req0_ready, rsp_id, rsp_result} !== {4'b1101, 32'h40C00000}) begin
                fails++;
                $display("[TB] FAIL mul_hold[%0d]: valid=%b busy=%b rdy0=%b id=%b res=%h, want 1 1 0 1 40c00000",
                         i, rsp_valid, busy, req0_ready, rsp_id, rsp_result);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        checks++;
        if (!ok || {rsp_id, rsp_result, rsp_flags} !== {e.id, e.result, e.flags} || e.id !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mul_rsp: ok=%b id=%b res=%h flg=%b, want 1 40c00000 000",
                     ok, rsp_id, rsp_result, rsp_flags);
        end
        // The waiting req0 add must be served once the response drains.
        wait_ready(0, ok);
        @(negedge clk);
        req0_valid = 1'b0;
        wait_rsp(n);
        ok = ok && rsp_valid && (exp_q.size() > 0);
        if (ok) e = exp_q.pop_front();
        checks++;
        if (!ok || {rsp_id, rsp_result} !== {1'b0, 32'h40000000} || rsp_result !== e.result) begin
            fails++;
            $display("[TB] FAIL waited_add: ok=%b id=%b res=%h, want 0 40000000", ok, rsp_id, rsp_result);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a0[2] = '{32'h40A00000, 32'h40C00000};
        logic [31:0] b0[2] = '{32'h3F800000, 32'h40000000};
        logic [1:0]  o0[2] = '{2'b00, 2'b11};
        logic [31:0] a1[2] = '{32'h40400000, 32'h3FC00000};
        logic [31:0] b1[2] = '{32'h3F800000, 32'h40000000};
        logic [1:0]  o1[2] = '{2'b01, 2'b10};
        logic        order[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        fork
            begin
                bit ok;
                for (int i = 0; i < 2; i++) begin
                    set_req(0, 1'b1, a0[i], b0[i], o0[i]);
                    #1;
                    wait_ready(0, ok);
                    @(negedge clk);
                end
                req0_valid = 1'b0;
            end
            begin
                bit ok;
                for (int i = 0; i < 2; i++) begin
                    set_req(1, 1'b1, a1[i], b1[i], o1[i]);
                    #1;
                    wait_ready(1, ok);
                    @(negedge clk);
                end
                req1_valid = 1'b0;
            end
            begin
                int   n;
                exp_t e;
                bit   ok;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    wait_rsp(n);
                    ok = rsp_valid && (exp_q.size() > 0);
                    if (ok) e = exp_q.pop_front();
                    checks++;
                    if (!ok || rsp_id !== order[i] || {rsp_id, rsp_result, rsp_flags} !== {e.id, e.result, e.flags}
                            || (cyc - e.acc_cyc - 1) !== e.lat) begin
                        fails++;
                        $display("[TB] FAIL b2b[%0d]: ok=%b id=%b res=%h lat=%0d, want id %b res %h lat %0d",
                                 i, ok, rsp_id, rsp_result, cyc - e.acc_cyc - 1, order[i], e.result, e.lat);
                    end
                end
            end
        join
        @(negedge clk);
    endtask

    task automatic test_reset_in_exec();
        bit ok;
        bit saw;
        apply_reset();
        @(negedge clk);
        set_req(0, 1'b1, 32'h40C00000, 32'h40400000, 2'b11);
        #1;
        wait_ready(0, ok);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || {rsp_valid, busy, alu_in1, alu_in2, alu_oper, rsp_result, rsp_flags, rsp_id} !== 103'd0) begin
            fails++;
            $display("[TB] FAIL rst_exec: accepted=%b valid=%b busy=%b in1=%h in2=%h op=%b res=%h, want 1 then all 0",
                     ok, rsp_valid, busy, alu_in1, alu_in2, alu_oper, rsp_result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rst_no_rsp: rsp_valid seen=%b, want 0", saw);
        end
        set_req(0, 1'b1, 32'h3F800000, 32'h40000000, 2'b00);
        set_req(1, 1'b1, 32'h40000000, 32'h40400000, 2'b10);
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL rst_tie: rdy0/rdy1=%b, want 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_drop_valid();
        bit saw;
        @(negedge clk);
        set_req(0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 2'b10);
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL drop_ready: req0_ready=%b, want 1", req0_ready);
        end
        #1;
        req0_valid = 1'b0;
        saw = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, alu_in1, alu_oper} !== 35'd0) begin
            fails++;
            $display("[TB] FAIL drop_idle: busy=%b in1=%h op=%b, want 0 00000000 00", busy, alu_in1, alu_oper);
        end
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) saw = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw !== 1'b0 || exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drop_no_rsp: rsp seen=%b queued=%0d, want 0 0", saw, exp_q.size());
        end
    endtask

    task automatic test_exceptions();
        logic [31:0] a[5]  = '{32'h7F800000, 32'h40000000, 32'h7F800000, 32'h7F800000, 32'h3F800000};
        logic [31:0] b[5]  = '{32'h3F800000, 32'h7F800000, 32'h7F800000, 32'h40000000, 32'h7F800000};
        logic [1:0]  op[5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        logic [15:0] want;
        bit   ok;
        int   n;
        exp_t e;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                @(negedge clk);
                force dut.err_count = 16'hFFFE;
                #1;
                release dut.err_count;
                exp_err = 16'hFFFE;
                #1;
                checks++;
                if (err_count !== 16'hFFFE) begin
                    fails++;
                    $display("[TB] FAIL err_preload: err_count=%h, want fffe", err_count);
                end
            end
            run_op(i % 2, a[i], b[i], op[i], e, n, ok);
            checks++;
            if (!ok || rsp_flags !== 3'b001 || {rsp_id, rsp_result, rsp_flags} !== {e.id, e.result, e.flags}) begin
                fails++;
                $display("[TB] FAIL exc_rsp[%0d]: ok=%b flg=%b id=%b res=%h, want 001 %b %h",
                         i, ok, rsp_flags, rsp_id, rsp_result, e.id, e.result);
            end
            if (ok && e.flags != 3'b000 && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
            @(negedge clk);
            want = (i < 3) ? 16'(i + 1) : 16'hFFFF;
            checks++;
            if (err_count !== want || err_count !== exp_err) begin
                fails++;
                $display("[TB] FAIL err_count[%0d]: err_count=%h, want %h", i, err_count, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_backpressure();
        test_back_to_back();
        test_reset_in_exec();
        test_drop_valid();
        test_exceptions();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fpu_op_scheduler.md
FPU_OP_SCHEDULER -- requirements
Module: fpu_op_scheduler

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  LAT_ADDSUB, 1, cycles the ALU operands are held before capture for oper 00/01 (range 1..15)
  LAT_MUL, 2, capture delay for oper 10 (range 1..15)
  LAT_DIV, 4, capture delay for oper 11 (range 1..15)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  req0_valid  in  1  requester 0 has an operation
  req0_ready  out  1  requester 0 operation accepted this cycle
  req0_a / req0_b  in  32  requester 0 IEEE-754 single operands
  req0_oper  in  2  00 add, 01 sub, 10 mul, 11 div
  req1_valid, req1_ready, req1_a, req1_b, req1_oper  same as requester 0, for requester 1
  alu_in1 / alu_in2  out  32  operands driven to the combinational FP ALU
  alu_oper  out  2  operation code driven to the ALU
  alu_result  in  32  ALU result
  alu_overflow / alu_underflow / alu_exception  in  1 each  ALU flags
  rsp_valid  out  1  response available
  rsp_ready  in  1  consumer accepts response
  rsp_id  out  1  requester index of response
  rsp_result  out  32  captured result
  rsp_flags  out  3  {overflow, underflow, exception} captured
  busy  out  1  high whenever state is not IDLE
  err_count  out  16  saturating count of delivered responses with any flag set

Function
REQ-003 The block SHALL implement the FSM states IDLE, EXEC and RESP, one operation in flight at a time.
REQ-004 In IDLE, grant SHALL go to the only valid requester; if both are valid, grant SHALL go to the requester not granted last (round-robin).
REQ-005 reqN_ready SHALL be asserted combinationally only in IDLE, and only for the granted requester; at most one ready SHALL be high per cycle.
REQ-006 On a valid&ready handshake, a/b/oper and the requester id SHALL be registered, the 4-bit counter SHALL load the latency for oper, last_grant SHALL update, and the FSM SHALL go to EXEC.
REQ-007 alu_in1, alu_in2 and alu_oper SHALL be driven from the operand registers and held stable from accept until capture.
REQ-008 In EXEC, the counter SHALL decrement each cycle; at count==1, alu_result and the flags SHALL be captured into rsp_* and the FSM SHALL go to RESP.
REQ-009 Latency: if accept occurs at edge k, rsp_valid SHALL rise after edge k+LAT.
REQ-010 In RESP, rsp_valid SHALL be high and rsp_* SHALL be stable until rsp_ready; on handshake the FSM SHALL return to IDLE, with no new accept in the same cycle; peak throughput is one operation per LAT+2 cycles.
REQ-011 On the response handshake, err_count SHALL increment by 1 if |rsp_flags, saturating at 16'hFFFF.
REQ-012 A requester dropping valid before ready SHALL be ignored; no partial capture SHALL occur.
REQ-013 Requests arriving while busy SHALL wait; they SHALL NOT be lost or reordered within a requester.

Reset
REQ-014 While rst_n is low, all registers SHALL clear asynchronously: state IDLE, operand/rsp registers 0, rsp_valid 0, busy 0, err_count 0, counter 0, and last_grant=1 so requester 0 wins the first tie.
REQ-015 Reset asserted during EXEC or RESP SHALL discard the in-flight operation with no response.
REQ-016 The block SHALL leave reset synchronously to clk, so the first accept is possible at the first rising edge after rst_n rises.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
  req0 add 0x3F800000+0x40000000 alone -> accept at edge k, rsp_valid after k+1, rsp_result 0x40400000, rsp_id 0, rsp_flags 000
  req1 mul 0x40000000*0x40400000, rsp_ready held low 5 cycles -> rsp_result 0x40C00000 stable throughout, busy high, req0 ready low
  req0 and req1 both valid for 4 operations -> grants 0,1,0,1; div op shows a 4-cycle accept-to-rsp_valid gap
  operand 0x7F800000 (exception) on each of three ops -> rsp_flags 001 each, err_count 3; preloaded 0xFFFF stays 0xFFFF
  rst_n pulsed low during EXEC of a div -> no rsp_valid, outputs 0, next tie grants requester 0
  req0_valid dropped in the same cycle it is granted -> state IDLE next cycle, no response generated
